// File: rtl/moore_seq_detector.sv
// Parametrised Moore serial pattern detector with valid qualifier, run-time pattern
// reload and saturating match counter. Define MOORE_SEQ_MASK_EN to add a don't-care mask port.
module moore_seq_detector #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_RST = 4'b1011,
  parameter bit                   OVERLAP     = 1'b1,
  parameter int                   CNT_W       = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             din_valid,
  input  logic                             din,
  input  logic                             pattern_load,
  input  logic [PATTERN_W-1:0]             pattern_in,
`ifdef MOORE_SEQ_MASK_EN
  input  logic [PATTERN_W-1:0]             pattern_mask_in,
`endif
  output logic                             dout,
  output logic [CNT_W-1:0]                 match_count,
  output logic [$clog2(PATTERN_W+1)-1:0]   state_o
);

  localparam int                SW      = $clog2(PATTERN_W + 1);
  localparam logic [SW-1:0]     MATCH_S = SW'(PATTERN_W);
  localparam logic [SW-1:0]     ZERO_S  = {SW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);

  logic [SW-1:0]        state_r, state_nxt_s, adv_s;
  logic                 dout_r, dout_nxt_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
  logic [PATTERN_W-1:0] pattern_r, pattern_nxt_s;
  logic [PATTERN_W-1:0] mask_r, mask_nxt_s;
  logic [PATTERN_W-1:0] load_mask_s;

`ifdef MOORE_SEQ_MASK_EN
  assign load_mask_s = pattern_mask_in;
`else
  assign load_mask_s = {PATTERN_W{1'b1}};
`endif

  // Longest suffix of (prefix of length s') followed by bit_in that equals a pattern
  // prefix; the candidate's earlier bits are the pattern's own leading bits.
  function automatic logic [SW-1:0] next_prefix(
    input logic [SW-1:0]        cur,
    input logic                 bit_in,
    input logic [PATTERN_W-1:0] pat,
    input logic [PATTERN_W-1:0] msk
  );
    int            base;
    int            cidx;
    int            pidx;
    logic          cbit;
    logic          ok;
    logic          found;
    logic [SW-1:0] best;
    if (cur == MATCH_S) begin
      base = OVERLAP ? PATTERN_W : 32'sd0;
    end else begin
      base = int'(cur);
    end
    best  = ZERO_S;
    found = 1'b0;
    for (int k = PATTERN_W; k >= 32'sd1; k--) begin
      ok = (k <= base + 32'sd1);
      for (int i = 0; i < PATTERN_W; i++) begin
        cidx = base + 32'sd1 - k + i;
        if (ok && (i < k) && (cidx >= 32'sd0)) begin
          pidx = (cidx < PATTERN_W) ? (PATTERN_W - 32'sd1 - cidx) : 32'sd0;
          cbit = (cidx == base) ? bit_in : pat[pidx];
          if (msk[PATTERN_W-1-i] && (cbit != pat[PATTERN_W-1-i])) begin
            ok = 1'b0;
          end else begin
            ok = ok;
          end
        end else begin
          ok = ok;
        end
      end
      if (ok && !found) begin
        best  = SW'(k);
        found = 1'b1;
      end else begin
        best  = best;
      end
    end
    return best;
  endfunction

  // Next-state, Moore flag and counter; load beats a valid bit on the same edge.
  always_comb begin
    state_nxt_s   = state_r;
    dout_nxt_s    = dout_r;
    cnt_nxt_s     = cnt_r;
    pattern_nxt_s = pattern_r;
    mask_nxt_s    = mask_r;
    adv_s         = next_prefix(state_r, din, pattern_r, mask_r);
    if (pattern_load) begin
      pattern_nxt_s = pattern_in;
      mask_nxt_s    = load_mask_s;
      state_nxt_s   = ZERO_S;
      dout_nxt_s    = 1'b0;
      cnt_nxt_s     = {CNT_W{1'b0}};
    end else if (din_valid) begin
      state_nxt_s = adv_s;
      dout_nxt_s  = (adv_s == MATCH_S);
      if ((adv_s == MATCH_S) && (cnt_r != CNT_MAX)) begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register; synchronous reset restores the power-on pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ZERO_S;
      dout_r    <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      pattern_r <= PATTERN_RST;
      mask_r    <= {PATTERN_W{1'b1}};
    end else begin
      state_r   <= state_nxt_s;
      dout_r    <= dout_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pattern_r <= pattern_nxt_s;
      mask_r    <= mask_nxt_s;
    end
  end

  assign dout        = dout_r;
  assign match_count = cnt_r;
  assign state_o     = state_r;

endmodule
